vend_ctrl_param: RTL
====================

Name: vend_ctrl_param

Overview:
- Parametrised successor to the fixed-price soda FSM. Accumulates nickel/dime/quarter credit against a programmable price and drives a product dispenser through a request/done handshake with timeout.
- Returns change or a cancelled balance one coin at a time, largest coin first, through a valid/ack coin-return handshake.
- Sits between the coin acceptor (single-cycle coin pulses) and the dispenser/coin-hopper drivers.

Parameters:
- PRICE_UNITS, 4, product price in 5-cent units (4 = 20c). Must be >= 1.
- CREDIT_W, 5, credit register width. Must hold PRICE_UNITS+4 (the maximum credit).
- VEND_TIMEOUT, 255, number of cycles to wait for vend_done before aborting. Must be >= 1.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- nickle, input, 1, coin pulse worth 1 unit.
- dime, input, 1, coin pulse worth 2 units.
- quarter, input, 1, coin pulse worth 5 units.
- cancel, input, 1, request a refund of the current credit.
- vend_done, input, 1, dispenser reports the product was delivered.
- coin_out_ack, input, 1, hopper has taken the presented coin.
- vend_req, output, 1, request a product.
- vend_fail, output, 1, one-cycle pulse when a vend times out.
- coin_reject, output, 1, one-cycle pulse when an inserted coin is not credited.
- coin_out_valid, output, 1, a change coin is presented.
- coin_out_type, output, 2, coin being presented: 01 nickel, 10 dime, 11 quarter, 00 when idle.
- credit, output, CREDIT_W, current credit in units.

Behaviour:
- All outputs are registered. On reset: state COLLECT, credit 0, timer 0, every output 0. Reset mid-vend or mid-change discards the credit and deasserts vend_req and coin_out_valid immediately.
- States are COLLECT, VEND and CHANGE.
- COLLECT:
  - Exactly one coin input high: credit <= credit + value.
  - If the new credit >= PRICE_UNITS, go to VEND; vend_req is high the next cycle.
  - Two or more coin inputs high in the same cycle: nothing is credited and coin_reject pulses the next cycle.
  - cancel with resulting credit > 0: go to CHANGE. A coin valid in the same cycle is credited first, so it is refunded with the rest.
  - cancel with credit 0: ignored.
- VEND:
  - vend_req stays high; the timer increments each cycle.
  - vend_done high: credit <= credit - PRICE_UNITS. Go to CHANGE if the remainder > 0, otherwise to COLLECT. vend_req drops the next cycle.
  - Timer reaches VEND_TIMEOUT-1 without vend_done: vend_fail pulses, credit is unchanged (full refund), go to CHANGE.
  - vend_done on the same cycle as the timeout: vend_done wins.
  - The timer clears on leaving VEND.
- CHANGE:
  - coin_out_valid is high. coin_out_type is chosen greedily: quarter if credit >= 5, else dime if credit >= 2, else nickel.
  - Type and valid stay stable until coin_out_ack.
  - On an ack cycle, credit is decremented by the coin value and the next type is recomputed the following cycle.
  - When credit reaches 0, valid drops and the state returns to COLLECT.
- Outside COLLECT, every coin pulse is rejected (coin_reject the next cycle, credit unchanged) and cancel is ignored.
- vend_done and coin_out_ack outside their own states are ignored.
- Coin values: nickle=1, dime=2, quarter=5. Worst case from COLLECT is (PRICE_UNITS-1)+5, so credit never overflows with legal parameters.

Test Plan (PRICE_UNITS=4, VEND_TIMEOUT=8):
- quarter pulse -> credit=5 and vend_req the next cycle; vend_done -> credit=1, coin_out_valid with type 01; ack -> credit=0, back to COLLECT.
- dime, dime -> credit=4, vend_req; vend_done -> credit=0, no coin_out_valid, COLLECT.
- nickle, dime, then cancel -> CHANGE with credit=3; dime presented, ack, nickel presented, ack; credit=0.
- quarter, no vend_done for 8 cycles -> vend_fail pulses once, quarter (11) presented, ack -> credit=0, vend_req low.
- In VEND, a nickle pulse, then nickle+dime together in COLLECT -> coin_reject pulses each time, credit unchanged.
- reset_n low while coin_out_valid=1 -> credit=0 and all outputs 0 asynchronously; normal operation resumes after release.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: collects nickel/dime/quarter credit against a
// programmable price, runs a vend handshake with timeout and pays change greedily.
module vend_ctrl_param #(
  parameter int PRICE_UNITS  = 4,
  parameter int CREDIT_W     = 5,
  parameter int VEND_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                nickle,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic                vend_done,
  input  logic                coin_out_ack,
  output logic                vend_req,
  output logic                vend_fail,
  output logic                coin_reject,
  output logic                coin_out_valid,
  output logic [1:0]          coin_out_type,
  output logic [CREDIT_W-1:0] credit
);

  // Timer only ever counts up to VEND_TIMEOUT-1.
  localparam int TIMER_W = (VEND_TIMEOUT > 1) ? $clog2(VEND_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(VEND_TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] PRICE      = CREDIT_W'(PRICE_UNITS);

  typedef enum logic [1:0] {
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic [1:0]          coin_count;
  logic                any_coin;
  logic                multi_coin;
  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] collect_credit;
  logic [CREDIT_W-1:0] vend_rem;
  logic [CREDIT_W-1:0] change_rem;

  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5))
      return 2'b11;
    else if (c >= CREDIT_W'(2))
      return 2'b10;
    else
      return 2'b01;
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] t);
    case (t)
      2'b11:   return CREDIT_W'(5);
      2'b10:   return CREDIT_W'(2);
      2'b01:   return CREDIT_W'(1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    coin_count = {1'b0, nickle} + {1'b0, dime} + {1'b0, quarter};
    any_coin   = (coin_count != 2'd0);
    multi_coin = (coin_count > 2'd1);
    coin_value = '0;
    if (coin_count == 2'd1) begin
      if (nickle)
        coin_value = CREDIT_W'(1);
      else if (dime)
        coin_value = CREDIT_W'(2);
      else
        coin_value = CREDIT_W'(5);
    end
    collect_credit = credit + coin_value;
    vend_rem       = credit - PRICE;
    change_rem     = credit - coin_units(coin_out_type);
  end

  // Cancel takes priority over reaching the price so a coin arriving with it is refunded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= COLLECT;
      timer          <= '0;
      credit         <= '0;
      vend_req       <= 1'b0;
      vend_fail      <= 1'b0;
      coin_reject    <= 1'b0;
      coin_out_valid <= 1'b0;
      coin_out_type  <= 2'b00;
    end else begin
      vend_fail   <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (multi_coin)
            coin_reject <= 1'b1;
          credit <= collect_credit;
          if (cancel && collect_credit != '0) begin
            state          <= CHANGE;
            coin_out_valid <= 1'b1;
            coin_out_type  <= pick_coin(collect_credit);
          end else if (collect_credit >= PRICE) begin
            state    <= VEND;
            vend_req <= 1'b1;
          end
        end

        VEND: begin
          if (any_coin)
            coin_reject <= 1'b1;
          if (vend_done) begin
            vend_req <= 1'b0;
            timer    <= '0;
            credit   <= vend_rem;
            if (vend_rem != '0) begin
              state          <= CHANGE;
              coin_out_valid <= 1'b1;
              coin_out_type  <= pick_coin(vend_rem);
            end else begin
              state <= COLLECT;
            end
          end else if (timer == TIMER_LAST) begin
            vend_fail      <= 1'b1;
            vend_req       <= 1'b0;
            timer          <= '0;
            state          <= CHANGE;
            coin_out_valid <= 1'b1;
            coin_out_type  <= pick_coin(credit);
          end else begin
            timer <= timer + 1'b1;
          end
        end

        CHANGE: begin
          if (any_coin)
            coin_reject <= 1'b1;
          if (coin_out_ack) begin
            credit <= change_rem;
            if (change_rem == '0) begin
              state          <= COLLECT;
              coin_out_valid <= 1'b0;
              coin_out_type  <= 2'b00;
            end else begin
              coin_out_type <= pick_coin(change_rem);
            end
          end
        end

        default: begin
          state          <= COLLECT;
          timer          <= '0;
          credit         <= '0;
          vend_req       <= 1'b0;
          coin_out_valid <= 1'b0;
          coin_out_type  <= 2'b00;
        end
      endcase
    end
  end

endmodule
